// File: rtl/pdm_cic_decimator.sv
// PDM microphone front end: generates pdm_clk, samples the 1-bit stream and
// decimates it to 16-bit PCM through a 3rd-order CIC filter with a valid/ready output.
module pdm_cic_decimator #(
  parameter int CLK_DIV    = 16,
  parameter int DECIM_LOG2 = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  output logic               pdm_clk,
  input  logic               pdm_data,
  output logic signed [15:0] pcm_out,
  output logic               pcm_valid,
  input  logic               pcm_ready,
  output logic               overrun,
  input  logic               overrun_clr
);

  localparam int DW    = $clog2(CLK_DIV);
  // Full-scale gain is exactly 2^(3*DECIM_LOG2); the extra top bit keeps a
  // constant +1 stream from aliasing onto negative full scale.
  localparam int ACC_W = 2 + 3 * DECIM_LOG2;
  localparam int SHIFT = 3 * DECIM_LOG2 - 15;

  localparam logic [DW-1:0]         DCNT_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0]         DCNT_HALF = DW'(CLK_DIV / 2);
  localparam logic signed [ACC_W-1:0] PCM_MAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] PCM_MIN = ACC_W'(-32768);

  logic [DW-1:0]          dcnt;
  logic [DECIM_LOG2-1:0]  tcnt;
  logic                   sync1;
  logic                   sync2;
  logic                   tick;
  logic                   strobe;
  logic signed [ACC_W-1:0] x;
  logic signed [ACC_W-1:0] int1, int2, int3;
  logic signed [ACC_W-1:0] int1_nxt, int2_nxt, int3_nxt;
  logic signed [ACC_W-1:0] dly1, dly2, dly3;
  logic signed [ACC_W-1:0] comb1, comb2, comb3;
  logic signed [ACC_W-1:0] shifted;
  logic signed [15:0]      result;

  assign tick = en && (dcnt == DCNT_LAST);
  assign x    = sync2 ? ACC_W'(1) : '1;

  assign int1_nxt = int1 + x;
  assign int2_nxt = int2 + int1_nxt;
  assign int3_nxt = int3 + int2_nxt;

  assign comb1   = int3 - dly1;
  assign comb2   = comb1 - dly2;
  assign comb3   = comb2 - dly3;
  assign shifted = comb3 >>> SHIFT;

  always_comb begin
    result = shifted[15:0];
    if (shifted > PCM_MAX)
      result = 16'sh7FFF;
    else if (shifted < PCM_MIN)
      result = 16'sh8000;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      dcnt    <= '0;
      pdm_clk <= 1'b0;
      tcnt    <= '0;
      strobe  <= 1'b0;
    end else begin
      sync1  <= pdm_data;
      sync2  <= sync1;
      strobe <= tick && (tcnt == '1);
      if (!en) begin
        dcnt    <= '0;
        pdm_clk <= 1'b0;
        tcnt    <= '0;
      end else begin
        dcnt    <= (dcnt == DCNT_LAST) ? '0 : dcnt + DW'(1);
        pdm_clk <= (dcnt >= DCNT_HALF);
        if (tick)
          tcnt <= tcnt + DECIM_LOG2'(1);
      end
    end
  end

  // Integrators advance once per PDM bit; combs once per decimated sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      int1 <= '0;
      int2 <= '0;
      int3 <= '0;
      dly1 <= '0;
      dly2 <= '0;
      dly3 <= '0;
    end else if (!en) begin
      int1 <= '0;
      int2 <= '0;
      int3 <= '0;
      dly1 <= '0;
      dly2 <= '0;
      dly3 <= '0;
    end else begin
      if (tick) begin
        int1 <= int1_nxt;
        int2 <= int2_nxt;
        int3 <= int3_nxt;
      end
      if (strobe) begin
        dly1 <= int3;
        dly2 <= comb1;
        dly3 <= comb2;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcm_out   <= '0;
      pcm_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (strobe) begin
        pcm_out   <= result;
        pcm_valid <= 1'b1;
      end else if (pcm_ready) begin
        pcm_valid <= 1'b0;
      end
      if (strobe && pcm_valid && !pcm_ready)
        overrun <= 1'b1;
      else if (overrun_clr)
        overrun <= 1'b0;
    end
  end

endmodule
